ternary_mvm_engine: RTL and testbench
=====================================

# ternary_mvm_engine

Parametrised ternary matrix-vector multiply engine and stream controller, the next generation of the chip-level load/multiply sequencer. It accepts command and data words on one `2*BIT_WIDTH`-bit input stream with valid/ready. It loads a runtime-sized ternary weight matrix (up to `IN_LEN` x `OUT_LEN`), accumulates signed input vectors against it, and drains saturated results one per handshake on a valid/ready output port. It sits between the pad-level input/output pin mapping and nothing else; it is the whole datapath of the tile.

## Interface
- `IN_LEN`, 16: maximum input-vector length (matrix rows); 2..16.
- `OUT_LEN`, 8: maximum output-vector length (matrix columns); 1..16.
- `BIT_WIDTH`, 8: signed element width; ≥8.
- `ACC_WIDTH`, `BIT_WIDTH+1+$clog2(IN_LEN)`: signed accumulator width.
- `clk` in 1: clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `in_data` in `2*BIT_WIDTH`: command or data word.
- `in_cmd` in 1: qualifies `in_data` as a command word.
- `in_valid` in 1: input word present.
- `in_ready` out 1: input accepted when `in_valid & in_ready`.
- `out_data` out `BIT_WIDTH`: saturated signed result.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `state` out 2: 0 IDLE, 1 LOAD, 2 MULT, 3 DRAIN.

## Operation
- Command word: opcode `[2BW-1:2BW-4]`, `R=[2BW-5:2BW-8]` = rows-1, `C=[2BW-9:2BW-12]` = cols-1. R and C saturate to `IN_LEN-1` and `OUT_LEN-1`.
- Opcodes: `A` = LOAD (latch rows/cols); `F` = MULT with stored dims and weights; `C` = clear all weights to 0; `0` = ABORT. All other opcodes are ignored.
- IDLE: accepts `A` (go to LOAD), `F` (go to MULT) and `C` (clear, stay in IDLE). Data words are accepted and discarded.
- LOAD: row-major, `ceil(cols/BW)` data words per row. Word w of row i writes columns `BW*w .. BW*w+BW-1`, 2 bits each, column `BW*w+k` at bits `[2k+1:2k]`.
- Weight encoding: `01`=+1, `11`=-1, `00` and `10`=0. Columns ≥ cols are discarded.
- After the last word of row rows-1, go to MULT with accumulators zeroed.
- MULT: each data word carries `x[2p]=in_data[2BW-1:BW]` and `x[2p+1]=in_data[BW-1:0]`, both signed.
- Each accepted word updates every j<cols: `acc[j] += w[2p][j]*x[2p] + w[2p+1][j]*x[2p+1]`. For odd rows, the second element of the last word is ignored.
- After `ceil(rows/2)` words, go to DRAIN.
- DRAIN: `in_ready=0`. Present `acc[0..cols-1]` in order, each clamped to `[-2^(BW-1), 2^(BW-1)-1]`.
- After the handshake on column cols-1, zero the accumulators and return to MULT for the next vector.
- ABORT (`0`) in LOAD or MULT: go to IDLE. Weights already written persist; partial accumulation is discarded. Commands other than `0` in LOAD or MULT are ignored.
- Reset values: state IDLE, dims rows=`IN_LEN` and cols=`OUT_LEN`, all weights 0, accumulators 0, `out_valid=0`, `out_data=0`, `in_ready=1`.

## Timing
- All transitions and weight/accumulator writes occur on the accepting `clk` edge. `in_ready` is combinational from state (`state!=DRAIN`).
- LOAD to MULT: `state` reads 2 the cycle after the final weight word.
- MULT to DRAIN: one cycle. `out_valid=1` with `acc[0]` the cycle after the final vector word, so latency from last word to first result is 1 cycle.
- Throughput: one input word per cycle in LOAD and MULT. One result per cycle in DRAIN while `out_ready=1`.
- Vector cost is `ceil(rows/2)+cols` cycles at full rate.
- `out_data`/`out_valid` hold stable while `out_valid & !out_ready`.
- DRAIN to MULT: `out_valid=0` and `in_ready=1` in the cycle after the last handshake.
- Asynchronous reset mid-LOAD, mid-MULT or mid-DRAIN immediately forces all reset values. No result is emitted afterward.
- `C` takes effect in one cycle; weights read 0 on the next edge.

## Test plan
- Reset: assert `rst_n=0` mid-DRAIN. Required: `out_valid=0`, `state=0`, `in_ready=1` immediately; a subsequent `F` plus one vector yields all-zero outputs.
- Basic 2x2: cmd `0xA110`; weights `0x000D` (row0: +1,-1) and `0x0005` (row1: +1,+1); vector `0x0305`. Required: outputs `0x08`, `0x02`, then `state=2`.
- Saturation: full 16x8 all +1 weights, then 8 words `0x7F7F`. Required: 8 outputs `0x7F`. Repeat with all -1 weights: 8 outputs `0x80`.
- Backpressure: during the basic 2x2 drain, hold `out_ready=0` for 5 cycles. Required: `0x08` held stable, `in_ready=0`, no input words accepted.
- Odd rows and ABORT: cmd `0xA200` (3 rows, 1 col), weights +1 on all rows, vectors `0x0102`, `0x0409`. Required: output `0x07` (9 ignored). Then cmd `0x0000` in MULT: `state=0`; cmd `0xF000` with vector `0x0102`, `0x0400` yields `0x07` again.
- Clear: cmd `0xC000` in IDLE, then `0xF000` and a full vector of `0x7F7F`. Required: all outputs `0x00`.

Source files
------------

// File: rtl/ternary_mvm_engine.sv
// Ternary matrix-vector multiply tile: loads runtime-sized 2-bit weights from a
// command/data stream, accumulates signed vector pairs and drains saturated results.
module ternary_mvm_engine #(
   parameter int IN_LEN    = 16,
   parameter int OUT_LEN   = 8,
   parameter int BIT_WIDTH = 8,
   parameter int ACC_WIDTH = BIT_WIDTH + 1 + $clog2(IN_LEN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2*BIT_WIDTH-1:0] in_data,
   input  logic                   in_cmd,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [BIT_WIDTH-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             state
);

   localparam int DW   = 2 * BIT_WIDTH;
   localparam int RW   = $clog2(IN_LEN);
   localparam int CW   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
   localparam int MAXW = (OUT_LEN + BIT_WIDTH - 1) / BIT_WIDTH;
   localparam int WW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
      {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MULT = 2'd2, DRAIN = 2'd3} state_t;

   state_t                       state_q, state_d;
   logic [RW-1:0]                rm1_q, rm1_d, row_q, row_d, rowp_q, rowp_d;
   logic [CW-1:0]                cm1_q, cm1_d, col_q, col_d;
   logic [WW-1:0]                word_q, word_d;
   logic [1:0]                   w_q [IN_LEN][OUT_LEN];
   logic [1:0]                   w_d [IN_LEN][OUT_LEN];
   logic signed [ACC_WIDTH-1:0]  acc_q [OUT_LEN];
   logic signed [ACC_WIDTH-1:0]  acc_d [OUT_LEN];
   logic                         out_valid_q, out_valid_d;
   logic [BIT_WIDTH-1:0]         out_data_q, out_data_d;

   logic                         accept, clear_acc;
   logic [3:0]                   opcode, r_fld, c_fld;
   logic [RW-1:0]                r_sat, r1;
   logic [CW-1:0]                c_sat, col_nx;
   logic signed [BIT_WIDTH-1:0]  x0, x1;

   function automatic logic signed [ACC_WIDTH-1:0] term(input logic [1:0] w,
                                                        input logic signed [BIT_WIDTH-1:0] x);
      logic signed [ACC_WIDTH-1:0] ext;
      ext = {{(ACC_WIDTH-BIT_WIDTH){x[BIT_WIDTH-1]}}, x};
      if (w == 2'b01)      return ext;
      else if (w == 2'b11) return -ext;
      else                 return '0;
   endfunction

   function automatic logic [BIT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
      if (a > SAT_HI)      return SAT_HI[BIT_WIDTH-1:0];
      else if (a < SAT_LO) return SAT_LO[BIT_WIDTH-1:0];
      else                 return a[BIT_WIDTH-1:0];
   endfunction

   assign in_ready  = (state_q != DRAIN);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign state     = state_q;

   assign accept = in_valid & in_ready;
   assign opcode = in_data[DW-1 -: 4];
   assign r_fld  = in_data[DW-5 -: 4];
   assign c_fld  = in_data[DW-9 -: 4];
   assign r_sat  = (int'(r_fld) > IN_LEN - 1)  ? RW'(IN_LEN - 1)  : RW'(r_fld);
   assign c_sat  = (int'(c_fld) > OUT_LEN - 1) ? CW'(OUT_LEN - 1) : CW'(c_fld);
   assign x0     = in_data[DW-1:BIT_WIDTH];
   assign x1     = in_data[BIT_WIDTH-1:0];
   assign r1     = rowp_q | RW'(1);
   assign col_nx = col_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      rm1_d       = rm1_q;
      cm1_d       = cm1_q;
      row_d       = row_q;
      word_d      = word_q;
      rowp_d      = rowp_q;
      col_d       = col_q;
      w_d         = w_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      clear_acc   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept && in_cmd) begin
               if (opcode == 4'hA) begin
                  rm1_d   = r_sat;
                  cm1_d   = c_sat;
                  row_d   = '0;
                  word_d  = '0;
                  state_d = LOAD;
               end else if (opcode == 4'hF) begin
                  rowp_d    = '0;
                  clear_acc = 1'b1;
                  state_d   = MULT;
               end else if (opcode == 4'hC) begin
                  for (int r = 0; r < IN_LEN; r++)
                     for (int c = 0; c < OUT_LEN; c++)
                        w_d[r][c] = 2'b00;
               end
            end
         end
         LOAD: begin
            if (accept && in_cmd) begin
               if (opcode == 4'h0) state_d = IDLE;
            end else if (accept) begin
               for (int c = 0; c < OUT_LEN; c++)
                  if ((c / BIT_WIDTH == int'(word_q)) && (c <= int'(cm1_q)))
                     w_d[row_q][c] = in_data[2*(c%BIT_WIDTH)+1 -: 2];
               if (int'(word_q) == int'(cm1_q) / BIT_WIDTH) begin
                  word_d = '0;
                  if (row_q == rm1_q) begin
                     rowp_d    = '0;
                     clear_acc = 1'b1;
                     state_d   = MULT;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  word_d = word_q + WW'(1);
               end
            end
         end
         MULT: begin
            if (accept && in_cmd) begin
               if (opcode == 4'h0) begin
                  clear_acc = 1'b1;
                  state_d   = IDLE;
               end
            end else if (accept) begin
               for (int j = 0; j < OUT_LEN; j++)
                  if (j <= int'(cm1_q))
                     acc_d[j] = acc_q[j] + term(w_q[rowp_q][j], x0)
                                + ((r1 <= rm1_q) ? term(w_q[r1][j], x1) : '0);
               // The first result is registered on the same edge as the last vector word.
               if (r1 >= rm1_q) begin
                  col_d       = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = sat(acc_d[0]);
                  state_d     = DRAIN;
               end else begin
                  rowp_d = rowp_q + RW'(2);
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (col_q == cm1_q) begin
                  out_valid_d = 1'b0;
                  rowp_d      = '0;
                  clear_acc   = 1'b1;
                  state_d     = MULT;
               end else begin
                  col_d      = col_nx;
                  out_data_d = sat(acc_q[col_nx]);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear_acc)
         for (int j = 0; j < OUT_LEN; j++)
            acc_d[j] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rm1_q       <= RW'(IN_LEN - 1);
         cm1_q       <= CW'(OUT_LEN - 1);
         row_q       <= '0;
         word_q      <= '0;
         rowp_q      <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int r = 0; r < IN_LEN; r++)
            for (int c = 0; c < OUT_LEN; c++)
               w_q[r][c] <= 2'b00;
         for (int j = 0; j < OUT_LEN; j++)
            acc_q[j] <= '0;
      end else begin
         state_q     <= state_d;
         rm1_q       <= rm1_d;
         cm1_q       <= cm1_d;
         row_q       <= row_d;
         word_q      <= word_d;
         rowp_q      <= rowp_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         w_q         <= w_d;
         acc_q       <= acc_d;
      end
   end

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Directed self-checking bench for ternary_mvm_engine: load, multiply, drain,
// saturation, backpressure, odd rows, abort, clear and asynchronous reset.
module tb_ternary_mvm_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_cmd = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   ternary_mvm_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_cmd    (in_cmd),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Presents one word at the falling edge, holds it across one rising edge.
   task automatic send(input logic [15:0] data, input logic cmd);
      @(negedge clk);
      in_data  = data;
      in_cmd   = cmd;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_cmd   = 1'b0;
   endtask

   // Waits (bounded) for a result, captures it, and lets the next edge consume it.
   task automatic get_out(output logic [7:0] d, output bit ok, output int lat);
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      ok  = out_valid;
      d   = out_data;
      lat = cnt;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [7:0] d;
      bit ok;
      int lat;
      send(16'hA110, 1'b1);
      checks++;
      if (state !== 2'd1) begin errors++; $display("[TB] FAIL basic_load_state: got %0d want 1", state); end
      send(16'h000D, 1'b0);
      send(16'h0005, 1'b0);
      checks++;
      if (state !== 2'd2) begin errors++; $display("[TB] FAIL basic_mult_state: got %0d want 2", state); end
      send(16'h0305, 1'b0);
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h08) begin errors++; $display("[TB] FAIL basic_out0: got %h want 08", d); end
      checks++;
      if (lat != 0) begin errors++; $display("[TB] FAIL basic_latency: got %0d extra cycles want 0", lat); end
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h02) begin errors++; $display("[TB] FAIL basic_out1: got %h want 02", d); end
      checks++;
      if (state !== 2'd2 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_after_drain: got state=%0d valid=%b ready=%b want 2/0/1", state, out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] d;
      bit ok;
      int lat;
      out_ready = 1'b0;
      send(16'h0305, 1'b0);
      in_data  = 16'h7F7F;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h08 || in_ready !== 1'b0 || state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h ready=%b state=%0d want 1/08/0/3",
                     i, out_valid, out_data, in_ready, state);
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h08) begin errors++; $display("[TB] FAIL bp_out0: got %h want 08", d); end
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h02) begin errors++; $display("[TB] FAIL bp_out1: got %h want 02", d); end
      // Stalled words must not have leaked into this vector: 1+2=3, -1+2=1.
      send(16'h0102, 1'b0);
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h03) begin errors++; $display("[TB] FAIL bp_next0: got %h want 03", d); end
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h01) begin errors++; $display("[TB] FAIL bp_next1: got %h want 01", d); end
   endtask

   task automatic test_saturation();
      logic [7:0] d;
      bit ok;
      int lat;
      logic [15:0] wword;
      logic [7:0]  want;
      for (int pass = 0; pass < 2; pass++) begin
         wword = (pass == 0) ? 16'h5555 : 16'hFFFF;
         want  = (pass == 0) ? 8'h7F : 8'h80;
         send(16'h0000, 1'b1);
         send(16'hAF70, 1'b1);
         for (int r = 0; r < 16; r++) send(wword, 1'b0);
         checks++;
         if (state !== 2'd2) begin errors++; $display("[TB] FAIL sat%0d_state: got %0d want 2", pass, state); end
         for (int p = 0; p < 8; p++) send(16'h7F7F, 1'b0);
         for (int j = 0; j < 8; j++) begin
            get_out(d, ok, lat);
            checks++;
            if (!ok || d !== want) begin errors++; $display("[TB] FAIL sat%0d_out%0d: got %h want %h", pass, j, d, want); end
         end
      end
   endtask

   task automatic test_odd_abort();
      logic [7:0] d;
      bit ok;
      int lat;
      send(16'h0000, 1'b1);
      send(16'hA200, 1'b1);
      for (int r = 0; r < 3; r++) send(16'h0001, 1'b0);
      send(16'h0102, 1'b0);
      send(16'h0409, 1'b0);
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h07) begin errors++; $display("[TB] FAIL odd_out: got %h want 07", d); end
      send(16'h0505, 1'b0);
      send(16'h0000, 1'b1);
      checks++;
      if (state !== 2'd0) begin errors++; $display("[TB] FAIL abort_state: got %0d want 0", state); end
      send(16'hF000, 1'b1);
      checks++;
      if (state !== 2'd2) begin errors++; $display("[TB] FAIL rerun_state: got %0d want 2", state); end
      send(16'h0102, 1'b0);
      send(16'h0400, 1'b0);
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h07) begin errors++; $display("[TB] FAIL abort_rerun_out: got %h want 07", d); end
   endtask

   task automatic test_clear();
      logic [7:0] d;
      bit ok;
      int lat;
      send(16'h0000, 1'b1);
      send(16'hC000, 1'b1);
      checks++;
      if (state !== 2'd0) begin errors++; $display("[TB] FAIL clear_state: got %0d want 0", state); end
      send(16'hF000, 1'b1);
      send(16'h7F7F, 1'b0);
      send(16'h7F7F, 1'b0);
      get_out(d, ok, lat);
      checks++;
      if (!ok || d !== 8'h00) begin errors++; $display("[TB] FAIL clear_out: got %h want 00", d); end
   endtask

   task automatic test_reset_mid_drain();
      logic [7:0] d;
      bit ok;
      int lat;
      send(16'h0000, 1'b1);
      send(16'hA110, 1'b1);
      send(16'h000D, 1'b0);
      send(16'h0005, 1'b0);
      out_ready = 1'b0;
      send(16'h0305, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || state !== 2'd3) begin
         errors++;
         $display("[TB] FAIL rst_pre_drain: got valid=%b state=%0d want 1/3", out_valid, state);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || state !== 2'd0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rst_async: got valid=%b state=%0d ready=%b data=%h want 0/0/1/00",
                  out_valid, state, in_ready, out_data);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_result%0d: got valid=%b want 0", i, out_valid); end
      end
      @(posedge clk);
      #1;
      send(16'hF000, 1'b1);
      for (int p = 0; p < 8; p++) send(16'h7F7F, 1'b0);
      for (int j = 0; j < 8; j++) begin
         get_out(d, ok, lat);
         checks++;
         if (!ok || d !== 8'h00) begin errors++; $display("[TB] FAIL rst_zero_out%0d: got %h want 00", j, d); end
      end
   endtask

   initial begin
      $display("[TB] starting ternary_mvm_engine bench");
      test_reset();
      test_basic();
      test_backpressure();
      test_saturation();
      test_odd_abort();
      test_clear();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
